// File: rtl/cam_pipe_pkg.sv
// Shared camera-pipeline constants: default raster geometry, coordinate widths
// and the mask pixel encoding produced by the morphology filter.
package cam_pipe_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;
    localparam int X_W_DEF      = 12;
    localparam int Y_W_DEF      = 11;

    localparam int                MASK_W  = 10;
    localparam logic [MASK_W-1:0] MASK_FG = 10'h3FF;
    localparam logic [MASK_W-1:0] MASK_BG = 10'h000;

endpackage

// File: rtl/blob_bbox_tracker_if.sv
// Pixel-in / bounding-box-out bundle between the mask stream and the tracker.
interface blob_bbox_tracker_if
    import cam_pipe_pkg::*;
#(
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int CNT_W = 20
) ();

    logic              iSOF;
    logic              iDVAL;
    logic [MASK_W-1:0] input_data;

    logic              oBOX_VALID;
    logic              oFOUND;
    logic [X_W-1:0]    oX_MIN;
    logic [X_W-1:0]    oX_MAX;
    logic [Y_W-1:0]    oY_MIN;
    logic [Y_W-1:0]    oY_MAX;
    logic [CNT_W-1:0]  oPIX_COUNT;

    modport master (
        output iSOF, iDVAL, input_data,
        input  oBOX_VALID, oFOUND, oX_MIN, oX_MAX, oY_MIN, oY_MAX, oPIX_COUNT
    );

    modport slave (
        input  iSOF, iDVAL, input_data,
        output oBOX_VALID, oFOUND, oX_MIN, oX_MAX, oY_MIN, oY_MAX, oPIX_COUNT
    );

endinterface

// File: rtl/raster_xy_counter.sv
// Raster position counter advanced by valid beats; o_x/o_y are the coordinates
// of the beat presented this cycle, o_last_pix flags the frame-completing beat.
module raster_xy_counter
    import cam_pipe_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF
) (
    input  logic           CLOCK,
    input  logic           RESET_N,
    input  logic           i_sof,
    input  logic           i_dval,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last_pix
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           w_last_pix;
    logic           w_restart;

    // A start-of-frame on the completing beat still lets that beat close the
    // old frame; the wrap to (0,0) then doubles as the restart.
    assign w_last_pix = i_dval && (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_restart  = i_sof && !w_last_pix;

    assign o_x        = w_restart ? '0 : r_x;
    assign o_y        = w_restart ? '0 : r_y;
    assign o_last_pix = w_last_pix;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_dval) begin
            if (o_x == X_LAST) begin
                r_x <= '0;
                r_y <= (o_y == Y_LAST) ? '0 : o_y + Y_W'(1);
            end else begin
                r_x <= o_x + X_W'(1);
                r_y <= o_y;
            end
        end else if (i_sof) begin
            r_x <= '0;
            r_y <= '0;
        end
    end

endmodule

// File: rtl/blob_bbox_tracker.sv
// Accumulates the bounding box and area of foreground mask pixels per frame
// and publishes them with a one-cycle pulse after the last pixel.
module blob_bbox_tracker
    import cam_pipe_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int FG_THRESH = 1,
    parameter int X_W       = X_W_DEF,
    parameter int Y_W       = Y_W_DEF,
    parameter int CNT_W     = 20
) (
    input logic                CLOCK,
    input logic                RESET_N,
    blob_bbox_tracker_if.slave bus
);

    localparam logic [X_W-1:0]    X_IDLE_MIN = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]    Y_IDLE_MIN = Y_W'(V_ACTIVE - 1);
    localparam logic [MASK_W-1:0] THRESH     = MASK_W'(FG_THRESH);

    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic             w_last_pix;
    logic             w_restart;
    logic             w_fg;

    logic [X_W-1:0]   r_xmin, r_xmax, w_b_xmin, w_b_xmax, w_n_xmin, w_n_xmax;
    logic [Y_W-1:0]   r_ymin, r_ymax, w_b_ymin, w_b_ymax, w_n_ymin, w_n_ymax;
    logic [CNT_W-1:0] r_cnt, w_b_cnt, w_n_cnt;

    logic             r_box_valid, r_found;
    logic [X_W-1:0]   r_o_xmin, r_o_xmax;
    logic [Y_W-1:0]   r_o_ymin, r_o_ymax;
    logic [CNT_W-1:0] r_o_cnt;

    raster_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_raster (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .i_sof      (bus.iSOF),
        .i_dval     (bus.iDVAL),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_last_pix (w_last_pix)
    );

    assign w_restart = bus.iSOF && !w_last_pix;
    assign w_fg      = bus.iDVAL && (bus.input_data >= THRESH);

    // NOTE: every signal gets its default before any branch so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_b_xmin = w_restart ? X_IDLE_MIN : r_xmin;
        w_b_xmax = w_restart ? '0         : r_xmax;
        w_b_ymin = w_restart ? Y_IDLE_MIN : r_ymin;
        w_b_ymax = w_restart ? '0         : r_ymax;
        w_b_cnt  = w_restart ? '0         : r_cnt;

        w_n_xmin = w_b_xmin;
        w_n_xmax = w_b_xmax;
        w_n_ymin = w_b_ymin;
        w_n_ymax = w_b_ymax;
        w_n_cnt  = w_b_cnt;

        if (w_fg) begin
            if (w_x < w_b_xmin) w_n_xmin = w_x;
            if (w_x > w_b_xmax) w_n_xmax = w_x;
            if (w_y < w_b_ymin) w_n_ymin = w_y;
            if (w_y > w_b_ymax) w_n_ymax = w_y;
            if (w_b_cnt != '1)  w_n_cnt  = w_b_cnt + CNT_W'(1);
        end
    end

    // Accumulators drop back to idle on the completing beat so the next beat
    // can start a new frame without an explicit start-of-frame.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_xmin <= X_IDLE_MIN;
            r_xmax <= '0;
            r_ymin <= Y_IDLE_MIN;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else if (w_last_pix) begin
            r_xmin <= X_IDLE_MIN;
            r_xmax <= '0;
            r_ymin <= Y_IDLE_MIN;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else begin
            r_xmin <= w_n_xmin;
            r_xmax <= w_n_xmax;
            r_ymin <= w_n_ymin;
            r_ymax <= w_n_ymax;
            r_cnt  <= w_n_cnt;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_box_valid <= 1'b0;
            r_found     <= 1'b0;
            r_o_xmin    <= '0;
            r_o_xmax    <= '0;
            r_o_ymin    <= '0;
            r_o_ymax    <= '0;
            r_o_cnt     <= '0;
        end else begin
            r_box_valid <= w_last_pix;
            if (w_last_pix) begin
                r_found  <= (w_n_cnt != '0);
                r_o_xmin <= (w_n_cnt != '0) ? w_n_xmin : '0;
                r_o_xmax <= (w_n_cnt != '0) ? w_n_xmax : '0;
                r_o_ymin <= (w_n_cnt != '0) ? w_n_ymin : '0;
                r_o_ymax <= (w_n_cnt != '0) ? w_n_ymax : '0;
                r_o_cnt  <= w_n_cnt;
            end
        end
    end

    assign bus.oBOX_VALID = r_box_valid;
    assign bus.oFOUND     = r_found;
    assign bus.oX_MIN     = r_o_xmin;
    assign bus.oX_MAX     = r_o_xmax;
    assign bus.oY_MIN     = r_o_ymin;
    assign bus.oY_MAX     = r_o_ymax;
    assign bus.oPIX_COUNT = r_o_cnt;

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Scoreboard bench for blob_bbox_tracker on an 8x4 raster with FG_THRESH = 512
// and a 4-bit saturating area counter.
module tb_blob_bbox_tracker;
    import cam_pipe_pkg::*;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int NPIX  = H * V;
    localparam int X_W   = 3;
    localparam int Y_W   = 2;
    localparam int CNT_W = 4;

    typedef struct {
        int found;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
        int cyc;
    } exp_t;

    logic CLOCK;
    logic RESET_N;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t m_e;
    logic [MASK_W-1:0] fr [NPIX];

    blob_bbox_tracker_if #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) bus ();

    blob_bbox_tracker #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .FG_THRESH (512),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .CNT_W     (CNT_W)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int f, input int x0, input int x1,
                                input int y0, input int y1, input int c);
        exp_t e;
        e.found = f; e.xmin = x0; e.xmax = x1;
        e.ymin = y0; e.ymax = y1; e.cnt = c; e.cyc = 0;
        return e;
    endfunction

    // Monitor: pops the oldest expectation on every published pulse.
    always @(posedge CLOCK) begin
        cyc = cyc + 1;
        #1;
        if (bus.oBOX_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                m_e = sb.pop_front();
                check("pulse_cycle", cyc, m_e.cyc);
                check("found", int'(bus.oFOUND), m_e.found);
                check("x_min", int'(bus.oX_MIN), m_e.xmin);
                check("x_max", int'(bus.oX_MAX), m_e.xmax);
                check("y_min", int'(bus.oY_MIN), m_e.ymin);
                check("y_max", int'(bus.oY_MAX), m_e.ymax);
                check("pix_count", int'(bus.oPIX_COUNT), m_e.cnt);
            end
        end
    end

    task automatic fill(input logic [MASK_W-1:0] v);
        for (int i = 0; i < NPIX; i++) fr[i] = v;
    endtask

    task automatic idle();
        @(negedge CLOCK);
        bus.iSOF       = 1'b0;
        bus.iDVAL      = 1'b0;
        bus.input_data = MASK_BG;
    endtask

    // sof_mode: 0 = none, 1 = strobe one cycle before, 2 = strobe on first beat
    task automatic send_frame(input int sof_mode, input int max_gap, input exp_t e);
        if (sof_mode == 1) begin
            @(negedge CLOCK);
            bus.iSOF  = 1'b1;
            bus.iDVAL = 1'b0;
        end
        for (int i = 0; i < NPIX; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(negedge CLOCK);
                    bus.iSOF       = 1'b0;
                    bus.iDVAL      = 1'b0;
                    bus.input_data = MASK_FG;
                end
            end
            @(negedge CLOCK);
            bus.iSOF       = (sof_mode == 2 && i == 0);
            bus.iDVAL      = 1'b1;
            bus.input_data = fr[i];
            if (i == NPIX - 1) begin
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
        end
        idle();
    endtask

    task automatic check_outputs(input string tag, input exp_t e, input int valid);
        check({tag, "_valid"}, int'(bus.oBOX_VALID), valid);
        check({tag, "_found"}, int'(bus.oFOUND), e.found);
        check({tag, "_xmin"},  int'(bus.oX_MIN), e.xmin);
        check({tag, "_xmax"},  int'(bus.oX_MAX), e.xmax);
        check({tag, "_ymin"},  int'(bus.oY_MIN), e.ymin);
        check({tag, "_ymax"},  int'(bus.oY_MAX), e.ymax);
        check({tag, "_count"}, int'(bus.oPIX_COUNT), e.cnt);
    endtask

    initial begin
        RESET_N        = 1'b0;
        bus.iSOF       = 1'b0;
        bus.iDVAL      = 1'b0;
        bus.input_data = MASK_BG;
        repeat (3) @(negedge CLOCK);
        check_outputs("reset", mk(0, 0, 0, 0, 0, 0), 0);
        RESET_N = 1'b1;
        idle();

        // 1: all background
        fill(MASK_BG);
        send_frame(1, 0, mk(0, 0, 0, 0, 0, 0));

        // 2: single pixel at (5,2), then outputs must hold
        fill(MASK_BG);
        fr[2*H+5] = MASK_FG;
        send_frame(1, 0, mk(1, 5, 5, 2, 2, 1));
        repeat (3) idle();
        check_outputs("hold", mk(1, 5, 5, 2, 2, 1), 0);

        // 3: scattered pixels incl. the final one; 512 sits exactly on the threshold
        fill(MASK_BG);
        fr[0*H+1] = MASK_FG;
        fr[3*H+6] = 10'd512;
        fr[1*H+3] = MASK_FG;
        fr[3*H+7] = MASK_FG;
        send_frame(1, 0, mk(1, 1, 7, 0, 3, 4));

        // 4: same frame with valid gaps carrying foreground data
        send_frame(1, 3, mk(1, 1, 7, 0, 3, 4));

        // 7: every pixel one below threshold
        fill(10'd511);
        send_frame(2, 0, mk(0, 0, 0, 0, 0, 0));

        // saturation, then back-to-back frame without any start-of-frame
        fill(MASK_FG);
        send_frame(0, 0, mk(1, 0, 7, 0, 3, 15));
        fill(MASK_BG);
        fr[7] = MASK_FG;
        send_frame(0, 0, mk(1, 7, 7, 0, 0, 1));

        // 5: abandoned partial frame, then restart on the first beat
        @(negedge CLOCK);
        bus.iSOF  = 1'b1;
        bus.iDVAL = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            bus.iSOF       = 1'b0;
            bus.iDVAL      = 1'b1;
            bus.input_data = MASK_FG;
        end
        fill(MASK_BG);
        fr[0] = MASK_FG;
        send_frame(2, 0, mk(1, 0, 0, 0, 0, 1));

        // 6: asynchronous reset between edges mid-frame
        fill(MASK_FG);
        @(negedge CLOCK);
        bus.iSOF = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK);
            bus.iSOF       = 1'b0;
            bus.iDVAL      = 1'b1;
            bus.input_data = MASK_FG;
        end
        @(posedge CLOCK);
        #2;
        RESET_N   = 1'b0;
        bus.iDVAL = 1'b0;
        #1;
        check_outputs("async_reset", mk(0, 0, 0, 0, 0, 0), 0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        fill(MASK_BG);
        fr[2*H+5] = MASK_FG;
        send_frame(1, 0, mk(1, 5, 5, 2, 2, 1));

        repeat (5) idle();
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
